timer_array: RTL and testbench
==============================

Name: timer_array

Overview:
- Parametrised multi-channel successor to the single SoC timer peripheral.
- Sits behind the bus bridge in the timer address window and uses the same peripheral bus signals: `addr`, `we`, `wdata`, combinational `rdata`.
- Provides N independent down-counters sharing one prescaler. Each channel runs one-shot or periodic, with sticky expiry flags and a registered, level-sensitive `irq` output.

Parameters:
- N_CH, 4, number of channels (1..14).
- CNT_W, 32, counter/LOAD width (1..32); register reads are zero-extended to 32.
- PRE_W, 16, prescaler width (1..32).

Ports:
- clk  input  1  peripheral clock, same as the CPU clock.
- rst  input  1  asynchronous, active-low reset; the bridge delivers it already inverted.
- addr  input  32  byte address; only addr[7:2] is decoded, the bridge has already selected the window.
- we  input  1  write strobe, one clk cycle per store.
- wdata  input  32  write data.
- rdata  output  32  combinational read data of the addressed register; 0 for unmapped offsets.
- irq  output  1  registered OR over channels of (FLAG & IE).
- pwm  output  N_CH  per-channel PWM; tied to 0 unless TIMER_PWM_EN is defined.

Behaviour:
- Register map, byte offsets:
  - 0x00 PRESC (RW, PRE_W bits).
  - 0x04 FLAGS (RO, bit i = channel i FLAG).
  - Channel i base = 0x10*(i+1):
    - +0x0 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IE.
    - +0x4 LOAD (RW).
    - +0x8 COUNT (RO).
    - +0xC STATUS: bit0 FLAG; write-1-to-clear.
  - Writes to unmapped or RO offsets are ignored.
- Reset (async, rst=0):
  - All registers and the prescaler count go to 0.
  - irq=0, pwm=0, rdata reflects the zeroed registers.
  - Reset asserted mid-count aborts immediately; no flag survives.
- Prescaler:
  - pcnt increments every clk.
  - When pcnt==PRESC: tick=1 for one cycle, then pcnt<=0.
  - PRESC=0 gives a tick every clk.
  - Writing PRESC clears pcnt in the same cycle.
- Channel start: a CTRL write with EN 0->1 loads COUNT<=LOAD in that cycle. A tick in the same cycle is ignored for that channel.
- On tick with EN=1:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0 (expiry):
    - FLAG<=1.
    - PERIODIC=1: COUNT<=LOAD.
    - PERIODIC=0: EN<=0, COUNT stays 0.
  - Period is therefore (LOAD+1)*(PRESC+1) clk cycles.
- Enable/mode changes:
  - EN=0 freezes COUNT. A later EN 0->1 reloads COUNT.
  - CTRL writes with EN unchanged=1 update PERIODIC/IE only; COUNT is untouched.
- LOAD writes while running take effect only at the next reload or start.
- Simultaneous events:
  - Expiry set and STATUS W1C in the same cycle: set wins, FLAG=1.
  - CTRL write and one-shot auto-clear of EN in the same cycle: the written value wins.
- irq is registered: it rises one clk after FLAG&IE becomes 1 and falls one clk after the clear.
- Read latency is 0 (combinational from state). COUNT read returns the pre-edge value.

Optional Feature:
- Macro: TIMER_PWM_EN.
- Defined:
  - Each channel adds CMP (RW, CNT_W) at +0x8 write; COUNT stays readable at +0x8.
  - CTRL bit3 is PWMEN.
  - pwm[i] is registered: 1 when EN & PWMEN & (COUNT < CMP), else 0.
  - CMP > LOAD gives a constant 1 while running.
- Undefined: pwm=0, CTRL bit3 reads 0, writes to +0x8 are ignored.

Decomposition:
- Shared package/defines header holds:
  - Offset constants: OFF_PRESC, OFF_FLAGS, CH_STRIDE, OFF_CTRL, OFF_LOAD, OFF_COUNT, OFF_STATUS.
  - CTRL bit indices: CTRL_EN, CTRL_PER, CTRL_IE, CTRL_PWMEN.
- One sub-module, timer_channel: per-channel CTRL/LOAD/COUNT/FLAG (and CMP/pwm), instantiated N_CH times in a generate loop.
- The top keeps the prescaler, address decode, read mux and irq register.

Test Plan:
- Reset/idle: rst=0 then 1, read every register -> all 0, irq=0. Unmapped read at 0xFC -> 0.
- One-shot timing:
  - Stimulus: PRESC=3, ch0 LOAD=4, CTRL=0x5.
  - FLAG set exactly 20 clk after the CTRL write cycle.
  - EN reads 0, COUNT=0, irq=1 one clk later.
  - Writing STATUS=1 drops irq next clk.
- Periodic:
  - Stimulus: PRESC=0, ch1 LOAD=2, CTRL=0x3.
  - Expiries every 3 clk; FLAGS reads 0x2.
  - Writing LOAD=5 mid-run: the next period stays 3 clk, later periods are 6.
- W1C race: clear STATUS in the exact cycle of a periodic expiry -> FLAG stays 1.
- Multi-channel: ch0 LOAD=1 and ch2 LOAD=3, both periodic, IE only on ch2 -> FLAGS=0x5, irq follows ch2 only.
- PWM (TIMER_PWM_EN):
  - Stimulus: PRESC=0, LOAD=9, CMP=3, PWMEN.
  - pwm[0] high 3 of every 10 clk.
  - Async reset mid-run forces pwm=0 and COUNT=0 immediately.

Source files
------------

// File: rtl/timer_array_pkg.sv
// timer_array_pkg: register offsets, CTRL bit positions and address helpers
// shared by timer_array and timer_channel.
package timer_array_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned CTRL_W = 4;

    // Global register offsets (byte addresses inside the timer window)
    localparam logic [7:0] OFF_PRESC   = 8'h00;
    localparam logic [7:0] OFF_FLAGS   = 8'h04;

    // Channel block layout: base = CH_STRIDE * (i + 1), register = offset & CH_REG_MASK
    localparam logic [7:0] CH_STRIDE   = 8'h10;
    localparam logic [7:0] CH_REG_MASK = 8'h0F;
    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_LOAD    = 8'h04;
    localparam logic [7:0] OFF_COUNT   = 8'h08;
    localparam logic [7:0] OFF_STATUS  = 8'h0C;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_PER   = 1;
    localparam int unsigned CTRL_IE    = 2;
    localparam int unsigned CTRL_PWMEN = 3;

    // Byte offset of channel idx's register block
    function automatic logic [7:0] ch_base(input int unsigned idx);
        return 8'(32'(CH_STRIDE) * (idx + 1));
    endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counter with CTRL/LOAD/COUNT/FLAG state and an
// optional PWM comparator (built when TIMER_PWM_EN is defined).
// Ports:
//   clk, rst                    clock, async active-low reset
//   tick                        shared prescaler tick
//   ctrl_we/load_we/cmp_we/status_we  decoded write strobes for this channel
//   wdata                       bus write data
//   ctrl                        {PWMEN, IE, PERIODIC, EN}
//   load, count, flag           register state for read-back
//   pwm                         registered PWM output (0 unless TIMER_PWM_EN)
module timer_channel
    import timer_array_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              ctrl_we,
    input  logic              load_we,
    input  logic              cmp_we,
    input  logic              status_we,
    input  logic [BUS_W-1:0]  wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  load,
    output logic [CNT_W-1:0]  count,
    output logic              flag,
    output logic              pwm
);

    logic [CTRL_W-1:0] ctrl_wr_c;
    logic [CTRL_W-1:0] ctrl_nxt_c;
    logic [CNT_W-1:0]  count_nxt_c;
    logic              flag_nxt_c;
    logic              start_c;
    logic              unused_c;

    // PWMEN only exists when the PWM comparator is built
`ifdef TIMER_PWM_EN
    assign ctrl_wr_c = wdata[CTRL_W-1:0];
`else
    assign ctrl_wr_c = {1'b0, wdata[CTRL_W-2:0]};
`endif

    // Next-state: W1C first so an expiry in the same cycle wins; a CTRL
    // write last so it overrides the one-shot auto-clear of EN.
    always_comb begin
        ctrl_nxt_c  = ctrl;
        count_nxt_c = count;
        flag_nxt_c  = flag;
        start_c     = ctrl_we && ctrl_wr_c[CTRL_EN] && !ctrl[CTRL_EN];

        if (status_we && wdata[0]) begin
            flag_nxt_c = 1'b0;
        end

        if (start_c) begin
            count_nxt_c = load;
        end else if (tick && ctrl[CTRL_EN]) begin
            if (count != '0) begin
                count_nxt_c = count - CNT_W'(1);
            end else begin
                flag_nxt_c = 1'b1;
                if (ctrl[CTRL_PER]) begin
                    count_nxt_c = load;
                end else begin
                    ctrl_nxt_c[CTRL_EN] = 1'b0;
                end
            end
        end

        if (ctrl_we) begin
            ctrl_nxt_c = ctrl_wr_c;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
            flag  <= 1'b0;
        end else begin
            ctrl  <= ctrl_nxt_c;
            count <= count_nxt_c;
            flag  <= flag_nxt_c;
            if (load_we) begin
                load <= wdata[CNT_W-1:0];
            end
        end
    end

`ifdef TIMER_PWM_EN
    logic [CNT_W-1:0] cmp;

    // Compare register and registered PWM output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp <= '0;
            pwm <= 1'b0;
        end else begin
            if (cmp_we) begin
                cmp <= wdata[CNT_W-1:0];
            end
            pwm <= ctrl[CTRL_EN] && ctrl[CTRL_PWMEN] && (count < cmp);
        end
    end

    assign unused_c = ^wdata;
`else
    assign pwm      = 1'b0;
    assign unused_c = ^{wdata, cmp_we};
`endif

endmodule

// File: rtl/timer_array.sv
// timer_array: N_CH down-counter channels sharing one prescaler, behind the
// peripheral bus (addr/we/wdata, combinational rdata).
// Optional feature macro: TIMER_PWM_EN (per-channel CMP register and pwm output).
// Ports:
//   clk, rst     clock, async active-low reset
//   addr         byte address, only addr[7:2] decoded
//   we, wdata    single-cycle write strobe and data
//   rdata        combinational read data, 0 for unmapped offsets
//   irq          registered OR of FLAG & IE over all channels
//   pwm          per-channel PWM outputs
module timer_array
    import timer_array_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq,
    output logic [N_CH-1:0]  pwm
);

    logic [7:0]        off_c;
    logic [7:0]        reg_c;
    logic [7:0]        blk_c;
    logic              presc_we_c;
    logic              tick_c;
    logic [PRE_W-1:0]  presc;
    logic [PRE_W-1:0]  pcnt;
    logic [CTRL_W-1:0] ch_ctrl  [N_CH];
    logic [CNT_W-1:0]  ch_load  [N_CH];
    logic [CNT_W-1:0]  ch_count [N_CH];
    logic [N_CH-1:0]   ch_flag;
    logic [N_CH-1:0]   ch_ie_c;
    logic              unused_c;

    assign off_c      = {addr[7:2], 2'b00};
    assign reg_c      = off_c & CH_REG_MASK;
    assign blk_c      = off_c & ~CH_REG_MASK;
    assign presc_we_c = we && (off_c == OFF_PRESC);
    assign unused_c   = ^{addr[31:8], addr[1:0]};

    // Shared prescaler: tick when pcnt reaches PRESC; a PRESC write restarts it
    assign tick_c = (pcnt == presc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (presc_we_c) begin
            presc <= wdata[PRE_W-1:0];
            pcnt  <= '0;
        end else if (tick_c) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRE_W'(1);
        end
    end

    // Channel instances with per-channel write decode
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [7:0] BASE = ch_base(i);
        logic sel_c;

        assign sel_c = we && (blk_c == BASE);

        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_c),
            .ctrl_we   (sel_c && (reg_c == OFF_CTRL)),
            .load_we   (sel_c && (reg_c == OFF_LOAD)),
            .cmp_we    (sel_c && (reg_c == OFF_COUNT)),
            .status_we (sel_c && (reg_c == OFF_STATUS)),
            .wdata     (wdata),
            .ctrl      (ch_ctrl[i]),
            .load      (ch_load[i]),
            .count     (ch_count[i]),
            .flag      (ch_flag[i]),
            .pwm       (pwm[i])
        );

        assign ch_ie_c[i] = ch_ctrl[i][CTRL_IE];
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (off_c == OFF_PRESC) begin
            rdata = 32'(presc);
        end else if (off_c == OFF_FLAGS) begin
            rdata = 32'(ch_flag);
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (blk_c == ch_base(i)) begin
                case (reg_c)
                    OFF_CTRL:   rdata = 32'(ch_ctrl[i]);
                    OFF_LOAD:   rdata = 32'(ch_load[i]);
                    OFF_COUNT:  rdata = 32'(ch_count[i]);
                    OFF_STATUS: rdata = 32'(ch_flag[i]);
                    default:    rdata = '0;
                endcase
            end
        end
    end

    // Registered interrupt request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(ch_flag & ch_ie_c);
        end
    end

endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array: self-checking bench for timer_array. Expected values are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_timer_array;

    localparam int unsigned N_CH = 4;

    logic            clk;
    logic            rst;
    logic [31:0]     addr;
    logic            we;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            irq;
    logic [N_CH-1:0] pwm;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    timer_array #(
        .N_CH  (N_CH),
        .CNT_W (32),
        .PRE_W (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .pwm   (pwm)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr = a;
        #1;
        check_eq(tag, rdata, exp_q.pop_front());
    endtask

    task automatic expect_irq(input string tag, input logic exp);
        exp_q.push_back(32'(exp));
        check_eq(tag, 32'(irq), exp_q.pop_front());
    endtask

    task automatic expect_pwm(input string tag, input logic [N_CH-1:0] exp);
        exp_q.push_back(32'(exp));
        check_eq(tag, 32'(pwm), exp_q.pop_front());
    endtask

    // One write edge: called between a negedge and the next posedge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hi;
        rst   = 1'b0;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;
        cycles(3);
        rst = 1'b1;

        // Reset / idle state
        expect_irq("irq_rst", 1'b0);
        expect_pwm("pwm_rst", '0);
        expect_reg("presc_rst", 32'h00, 32'h0);
        expect_reg("flags_rst", 32'h04, 32'h0);
        for (int c = 0; c < N_CH; c++) begin
            expect_reg($sformatf("ctrl%0d_rst", c),   32'(16 * (c + 1)),      32'h0);
            expect_reg($sformatf("load%0d_rst", c),   32'(16 * (c + 1) + 4),  32'h0);
            expect_reg($sformatf("count%0d_rst", c),  32'(16 * (c + 1) + 8),  32'h0);
            expect_reg($sformatf("status%0d_rst", c), 32'(16 * (c + 1) + 12), 32'h0);
        end
        expect_reg("unmapped_fc", 32'hFC, 32'h0);
        expect_reg("unmapped_08", 32'h08, 32'h0);

        // Writes to read-only / unmapped offsets are ignored
        bus_write(32'h18, 32'h55);
        bus_write(32'hFC, 32'hFF);
        bus_write(32'h04, 32'hF);
        expect_reg("count0_ro", 32'h18, 32'h0);
        expect_reg("fc_wr_ignored", 32'hFC, 32'h0);
        expect_reg("flags_ro", 32'h04, 32'h0);

        // Width boundaries and CTRL bit3
        bus_write(32'h00, 32'h0001_2345);
        expect_reg("presc_width", 32'h00, 32'h0000_2345);
        bus_write(32'h34, 32'hFFFF_FFFF);
        expect_reg("load3_full", 32'h34, 32'hFFFF_FFFF);
        bus_write(32'h30, 32'h8);
`ifdef TIMER_PWM_EN
        expect_reg("ctrl3_pwmen", 32'h30, 32'h8);
`else
        expect_reg("ctrl3_pwmen", 32'h30, 32'h0);
`endif

        // One-shot: PRESC=3, LOAD=4 -> FLAG 20 clk after the CTRL write
        bus_write(32'h00, 32'd3);
        bus_write(32'h14, 32'd4);
        cycles(2);
        bus_write(32'h10, 32'h5);
        expect_reg("os_count_start", 32'h18, 32'd4);
        expect_reg("os_ctrl_start", 32'h10, 32'h5);
        expect_reg("os_load_hi_addr", 32'hABCD_0014, 32'd4);
        cycles(19);
        expect_reg("os_flag_19", 32'h1C, 32'h0);
        expect_reg("os_count_19", 32'h18, 32'h0);
        expect_reg("os_ctrl_19", 32'h10, 32'h5);
        cycles(1);
        expect_reg("os_flag_20", 32'h1C, 32'h1);
        expect_reg("os_ctrl_20", 32'h10, 32'h4);
        expect_reg("os_count_20", 32'h18, 32'h0);
        expect_reg("os_flags_20", 32'h04, 32'h1);
        expect_irq("os_irq_20", 1'b0);
        expect_pwm("os_pwm", '0);
        cycles(1);
        expect_irq("os_irq_21", 1'b1);
        bus_write(32'h1C, 32'h1);
        expect_reg("os_flag_w1c", 32'h1C, 32'h0);
        expect_irq("os_irq_w1c_0", 1'b1);
        cycles(1);
        expect_irq("os_irq_w1c_1", 1'b0);

        // Periodic: PRESC=0, ch1 LOAD=2 -> expiry every 3 clk
        bus_write(32'h00, 32'd0);
        bus_write(32'h24, 32'd2);
        bus_write(32'h20, 32'h3);
        expect_reg("per_count_s0", 32'h28, 32'd2);
        cycles(2);
        expect_reg("per_count_s2", 32'h28, 32'd0);
        expect_reg("per_flag_s2", 32'h2C, 32'h0);
        cycles(1);
        expect_reg("per_flag_s3", 32'h2C, 32'h1);
        expect_reg("per_count_s3", 32'h28, 32'd2);
        expect_reg("per_flags_s3", 32'h04, 32'h2);
        expect_irq("per_irq_no_ie", 1'b0);
        bus_write(32'h24, 32'd5);
        expect_reg("per_count_s4", 32'h28, 32'd1);
        cycles(2);
        expect_reg("per_reload_s6", 32'h28, 32'd5);
        cycles(5);
        expect_reg("per_count_s11", 32'h28, 32'd0);
        cycles(1);
        expect_reg("per_reload_s12", 32'h28, 32'd5);
        bus_write(32'h2C, 32'h1);
        expect_reg("per_w1c_s13", 32'h2C, 32'h0);
        expect_reg("per_count_s13", 32'h28, 32'd4);
        cycles(4);
        expect_reg("per_flag_s17", 32'h2C, 32'h0);
        // W1C in the exact expiry cycle: set wins
        bus_write(32'h2C, 32'h1);
        expect_reg("race_flag", 32'h2C, 32'h1);
        expect_reg("race_count", 32'h28, 32'd5);
        bus_write(32'h20, 32'h0);
        expect_reg("per_ctrl_off", 32'h20, 32'h0);

        // Async reset clears flags immediately
        rst = 1'b0;
        expect_reg("rst_flags", 32'h04, 32'h0);
        expect_reg("rst_load1", 32'h24, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Multi-channel: ch0 LOAD=1, ch2 LOAD=3, IE only on ch2
        bus_write(32'h00, 32'd0);
        bus_write(32'h14, 32'd1);
        bus_write(32'h34, 32'd3);
        bus_write(32'h10, 32'h3);
        bus_write(32'h30, 32'h7);
        expect_reg("mc_count0_a1", 32'h18, 32'd0);
        expect_reg("mc_count2_a1", 32'h38, 32'd3);
        cycles(1);
        expect_reg("mc_flags_a2", 32'h04, 32'h1);
        expect_irq("mc_irq_a2", 1'b0);
        cycles(3);
        expect_reg("mc_flags_a5", 32'h04, 32'h5);
        expect_irq("mc_irq_a5", 1'b0);
        cycles(1);
        expect_irq("mc_irq_a6", 1'b1);
        bus_write(32'h1C, 32'h1);
        expect_reg("mc_flags_a7", 32'h04, 32'h4);
        expect_irq("mc_irq_a7", 1'b1);
        bus_write(32'h30, 32'h3);
        expect_reg("mc_ctrl2_a8", 32'h30, 32'h3);
        expect_reg("mc_count2_a8", 32'h38, 32'd0);
        expect_irq("mc_irq_a8", 1'b1);
        cycles(1);
        expect_reg("mc_flags_a9", 32'h04, 32'h5);
        expect_irq("mc_irq_a9", 1'b0);
        bus_write(32'h30, 32'h7);
        cycles(1);
        expect_irq("mc_irq_a11", 1'b1);

        // Reset mid-run
        rst = 1'b0;
        #1;
        expect_irq("mid_rst_irq", 1'b0);
        expect_pwm("mid_rst_pwm", '0);
        expect_reg("mid_rst_count2", 32'h38, 32'h0);
        expect_reg("mid_rst_ctrl2", 32'h30, 32'h0);
        expect_reg("mid_rst_flags", 32'h04, 32'h0);
        @(negedge clk);
        rst = 1'b1;

`ifdef TIMER_PWM_EN
        // PWM: LOAD=9, CMP=3 -> high 3 of every 10 clk
        bus_write(32'h00, 32'd0);
        bus_write(32'h14, 32'd9);
        bus_write(32'h18, 32'd3);
        bus_write(32'h10, 32'hB);
        expect_reg("pwm_count_s0", 32'h18, 32'd9);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            cycles(1);
            if (pwm[0]) hi++;
        end
        check_eq("pwm_duty_20clk", 32'(hi), 32'd6);
        expect_pwm("pwm_s20", 4'b0001);
        rst = 1'b0;
        #1;
        expect_pwm("pwm_async_rst", '0);
        expect_reg("pwm_rst_count", 32'h18, 32'h0);
        @(negedge clk);
        rst = 1'b1;
`else
        hi = 0;
        bus_write(32'h00, 32'd0);
        bus_write(32'h14, 32'd9);
        bus_write(32'h10, 32'hB);
        for (int k = 0; k < 20; k++) begin
            cycles(1);
            if (pwm != '0) hi++;
        end
        check_eq("pwm_tied_low", 32'(hi), 32'd0);
        expect_reg("ctrl0_no_pwmen", 32'h10, 32'h3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
